// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D memory-port arbiter.
// Imported by mem_arbiter and its round-robin picker.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 256;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int CNT_W_DEF       = 7;

  // Requester IDs, also the encoding of the last-grant register
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    REL     = 2'd3
  } arb_state_t;

  function automatic logic is_grant(input arb_state_t s);
    return (s == GRANT_I) || (s == GRANT_D);
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright,
// a tie goes to whichever side was not granted last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_gnt_id,
  output logic       o_gnt_valid
);

  always_comb begin
    o_gnt_valid = |i_req;
    o_gnt_id    = REQ_I;
    case (i_req)
      2'b01:   o_gnt_id = REQ_I;
      2'b10:   o_gnt_id = REQ_D;
      2'b11:   o_gnt_id = ~i_last;
      default: o_gnt_id = REQ_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single off-chip line port between the I-cache and D-cache
// controllers, forwards the memory ack to the granted side, and flags stuck grants.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_enable_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ack_o,
  input  logic              d_enable_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  arb_state_t       r_state;
  logic             r_last_gnt;
  logic [CNT_W-1:0] r_wdog;
  logic             r_err;

  logic             w_gnt_id;
  logic             w_gnt_valid;
  logic [CNT_W-1:0] w_wdog_sat;

  mem_arb_rr_pick u_pick (
    .i_req       ({d_enable_i, i_enable_i}),
    .i_last      (r_last_gnt),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_valid (w_gnt_valid)
  );

  // Saturating increment so a very long stall cannot wrap back below the limit
  assign w_wdog_sat = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= IDLE;
      r_last_gnt <= REQ_I;
      r_wdog     <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_valid) begin
            r_state    <= (w_gnt_id == REQ_D) ? GRANT_D : GRANT_I;
            r_last_gnt <= w_gnt_id;
            r_wdog     <= '0;
          end
        end
        GRANT_I, GRANT_D: begin
          if (mem_ack_i) begin
            r_state <= REL;
          end else begin
            r_wdog <= w_wdog_sat;
            if (w_wdog_sat >= TIMEOUT_LIM) begin
              r_err <= 1'b1;
            end
          end
        end
        REL:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Port mux follows the registered state; acks pass straight through in grant
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    i_ack_o      = 1'b0;
    d_ack_o      = 1'b0;
    case (r_state)
      GRANT_I: begin
        mem_enable_o = 1'b1;
        mem_write_o  = i_write_i;
        mem_addr_o   = i_addr_i;
        mem_data_o   = i_data_i;
        i_ack_o      = mem_ack_i;
      end
      GRANT_D: begin
        mem_enable_o = 1'b1;
        mem_write_o  = d_write_i;
        mem_addr_o   = d_addr_i;
        mem_data_o   = d_data_i;
        d_ack_o      = mem_ack_i;
      end
      default: ;
    endcase
  end

  assign rd_data_o = mem_data_i;
  assign busy_o    = is_grant(r_state);
  assign err_o     = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of back-to-back transactions
// plus hand sequences for spurious ack, watchdog and asynchronous reset.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          i_enable_i = 1'b0, i_write_i = 1'b0;
  logic [AW-1:0] i_addr_i = '0;
  logic [DW-1:0] i_data_i = '0;
  logic          i_ack_o;
  logic          d_enable_i = 1'b0, d_write_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_data_i = '0;
  logic          d_ack_o;
  logic [DW-1:0] rd_data_o;
  logic [DW-1:0] mem_data_i = '0;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_data_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_enable_o, mem_write_o, busy_o, err_o;

  mem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_enable_i(i_enable_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i),
    .i_data_i(i_data_i), .i_ack_o(i_ack_o),
    .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_ack_o(d_ack_o),
    .rd_data_o(rd_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o), .mem_enable_o(mem_enable_o),
    .mem_write_o(mem_write_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          i_en;
    logic          i_wr;
    logic [AW-1:0] i_addr;
    logic [7:0]    i_byte;
    logic          d_en;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_byte;
    int            delay;
    logic          exp_id;
    logic [AW-1:0] exp_addr;
    logic          exp_wr;
    logic [7:0]    exp_byte;
  } vec_t;

  typedef struct {
    logic          id;
    logic [DW-1:0] rdata;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vt[9];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    i_enable_i = v.i_en;  i_write_i = v.i_wr;  i_addr_i = v.i_addr;  i_data_i = {32{v.i_byte}};
    d_enable_i = v.d_en;  d_write_i = v.d_wr;  d_addr_i = v.d_addr;  d_data_i = {32{v.d_byte}};
    sb_q.push_back('{v.exp_id, mem_rd(v.exp_addr)});
  endtask

  // Returns the number of falling edges until mem_enable_o is seen
  task automatic wait_grant(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!mem_enable_o && n < 20);
    if (!mem_enable_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no grant within %0d cycles expected grant", name, n);
    end
  endtask

  // Called at a falling edge inside a grant: pulse the ack and score it
  task automatic do_ack(input string name);
    sb_t e;
    mem_data_i = mem_rd(mem_addr_o);
    mem_ack_i  = 1'b1;
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb got ack with empty scoreboard expected none", name);
    end else begin
      e = sb_q.pop_front();
      chk({name, "_ack"}, {d_ack_o, i_ack_o}, (e.id == REQ_D) ? 2'b10 : 2'b01);
      chk({name, "_rdata"}, rd_data_o, e.rdata);
    end
    @(posedge clk_i);
    #1;
    mem_ack_i  = 1'b0;
    mem_data_i = {8{$urandom}};
  endtask

  task automatic drop_all();
    i_enable_i = 1'b0;
    d_enable_i = 1'b0;
    i_write_i  = 1'b0;
    d_write_i  = 1'b0;
  endtask

  initial begin
    int   n;
    logic hold_ok;
    int   first_err;
    vec_t v;

    // {i_en,i_wr,i_addr,i_byte, d_en,d_wr,d_addr,d_byte, delay, exp_id,exp_addr,exp_wr,exp_byte}
    vt[0] = '{1, 0, 32'h100, 8'h11, 1, 0, 32'h200, 8'h22, 3,  REQ_D, 32'h200, 0, 8'h22};
    vt[1] = '{1, 0, 32'h100, 8'h11, 1, 0, 32'h200, 8'h22, 1,  REQ_I, 32'h100, 0, 8'h11};
    vt[2] = '{1, 0, 32'h100, 8'h11, 1, 0, 32'h200, 8'h22, 0,  REQ_D, 32'h200, 0, 8'h22};
    vt[3] = '{1, 0, 32'h100, 8'h11, 1, 0, 32'h200, 8'h22, 2,  REQ_I, 32'h100, 0, 8'h11};
    vt[4] = '{0, 0, 32'h000, 8'h00, 1, 1, 32'h300, 8'hA5, 4,  REQ_D, 32'h300, 1, 8'hA5};
    vt[5] = '{0, 0, 32'h000, 8'h00, 1, 0, 32'h340, 8'h77, 1,  REQ_D, 32'h340, 0, 8'h77};
    vt[6] = '{1, 1, 32'h180, 8'h5A, 0, 0, 32'h000, 8'h00, 2,  REQ_I, 32'h180, 1, 8'h5A};
    vt[7] = '{0, 0, 32'h000, 8'h00, 1, 0, 32'h400, 8'h33, 10, REQ_D, 32'h400, 0, 8'h33};
    vt[8] = '{1, 0, 32'h140, 8'h44, 1, 0, 32'h240, 8'h55, 1,  REQ_I, 32'h140, 0, 8'h44};

    // Asynchronous reset, checked before any clock edge
    #2 rst_i = 1'b0;
    #1;
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_acks", {i_ack_o, d_ack_o}, 0);
    chk("rst_addr_data_wr", {mem_addr_o, mem_data_o, mem_write_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Back-to-back table: each grant must land two falling edges after REL
    drive_vec(vt[0]);
    for (int k = 0; k < 9; k++) begin
      v = vt[k];
      wait_grant($sformatf("v%0d", k), n);
      chk($sformatf("v%0d_latency", k), n, 2);
      chk($sformatf("v%0d_addr", k), mem_addr_o, v.exp_addr);
      chk($sformatf("v%0d_write", k), mem_write_o, v.exp_wr);
      chk($sformatf("v%0d_wdata", k), mem_data_o, {32{v.exp_byte}});
      chk($sformatf("v%0d_busy", k), busy_o, 1);
      hold_ok = 1'b1;
      for (int c = 0; c < v.delay; c++) begin
        @(negedge clk_i);
        if (!mem_enable_o || i_ack_o || d_ack_o || mem_addr_o !== v.exp_addr) hold_ok = 1'b0;
      end
      chk($sformatf("v%0d_hold", k), hold_ok, 1);
      do_ack($sformatf("v%0d", k));
      if (k < 8) drive_vec(vt[k + 1]);
      else drop_all();
      @(negedge clk_i);
      chk($sformatf("v%0d_rel", k), {mem_enable_o, busy_o, i_ack_o, d_ack_o}, 0);
    end

    // Spurious ack while idle
    @(negedge clk_i);
    mem_data_i = {8{32'hDEAD_BEEF}};
    mem_ack_i  = 1'b1;
    #1;
    chk("spur_acks", {i_ack_o, d_ack_o}, 0);
    @(posedge clk_i);
    #1 mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("spur_idle", {mem_enable_o, busy_o}, 0);

    // Watchdog: 64 unacked grant cycles set err_o in the 65th
    @(posedge clk_i);
    #1;
    d_enable_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h500; d_data_i = '0;
    sb_q.push_back('{REQ_D, mem_rd(32'h500)});
    wait_grant("wdog", n);
    hold_ok   = 1'b1;
    first_err = 0;
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) @(negedge clk_i);
      if (!mem_enable_o || mem_addr_o !== 32'h500) hold_ok = 1'b0;
      if (err_o && first_err == 0) first_err = c;
    end
    chk("wdog_err_cycle", first_err, 65);
    chk("wdog_hold", hold_ok, 1);
    chk("wdog_err_high", err_o, 1);
    do_ack("wdog_late");
    d_enable_i = 1'b0;
    @(negedge clk_i);
    chk("wdog_err_sticky", err_o, 1);

    // Asynchronous reset in the middle of an I write grant
    i_enable_i = 1'b1; i_write_i = 1'b1; i_addr_i = 32'h600; i_data_i = {32{8'h3C}};
    wait_grant("rstmid", n);
    chk("rstmid_addr", mem_addr_o, 32'h600);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("rstmid_enable_busy", {mem_enable_o, busy_o}, 0);
    chk("rstmid_err", err_o, 0);
    chk("rstmid_port", {mem_addr_o, mem_data_o, mem_write_o}, 0);
    d_enable_i = 1'b1; d_write_i = 1'b0; d_addr_i = 32'h700; d_data_i = {32{8'h66}};
    @(negedge clk_i);
    rst_i = 1'b1;
    sb_q.push_back('{REQ_D, mem_rd(32'h700)});
    wait_grant("rstmid_tie", n);
    chk("rstmid_tie_latency", n, 1);
    chk("rstmid_tie_addr", mem_addr_o, 32'h700);
    do_ack("rstmid_tie");
    drop_all();

    // Reset with last grant = D must still hand the next tie to D
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    i_enable_i = 1'b1; i_addr_i = 32'h100; d_enable_i = 1'b1; d_addr_i = 32'h200;
    sb_q.push_back('{REQ_D, mem_rd(32'h200)});
    wait_grant("rst_tie", n);
    chk("rst_tie_addr", mem_addr_o, 32'h200);
    do_ack("rst_tie");
    drop_all();
    repeat (3) @(negedge clk_i);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
